// File: rtl/sfq_xor_pkg.sv
// Shared types and timing helpers for the RSFQ XOR cell sequencer.
// Sequencer state encoding plus per-bit and flush cycle arithmetic.
package sfq_xor_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FCLK,
    S_FWIN,
    S_FHOLD,
    S_A,
    S_SEP,
    S_B,
    S_SETUP,
    S_CLK,
    S_WIN,
    S_HOLD,
    S_RESP,
    S_DONE
  } state_t;

  localparam int MIN_SEP   = 1;
  localparam int MIN_SETUP = 1;
  localparam int MIN_WIN   = 1;
  localparam int MIN_HOLD  = 0;

  function automatic int per_bit_cycles(
    input int sep, input int setup,
    input int win, input int hold);
    return 3 + sep + setup + win + hold;
  endfunction

  function automatic int flush_cycles(
    input int win, input int hold);
    return 1 + win + hold;
  endfunction

  function automatic logic spacing_ok(
    input int width, input int sep,
    input int setup, input int win,
    input int hold);
    return (width >= 1) && (width <= 32)
      && (sep >= MIN_SEP)
      && (setup >= MIN_SETUP)
      && (win >= MIN_WIN)
      && (hold >= MIN_HOLD);
  endfunction

endpackage

// File: rtl/sfq_gap_counter.sv
// Loadable down-counter timing the idle gaps.
// Loading N keeps done low for N-1 cycles, so a state lasts N cycles.
module sfq_gap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);

  logic [W-1:0] cnt;

  // count down from the loaded length, park at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sfq_xor_sequencer.sv
// Serial word engine driving one clocked RSFQ XOR cell.
// Flushes the cell, then pulses a/b/clk per bit, LSB first.
module sfq_xor_sequencer
  import sfq_xor_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEP_CYC   = 2,
  parameter int SETUP_CYC = 3,
  parameter int OUT_WIN   = 4,
  parameter int HOLD_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_mismatch,
  output logic             rsp_glitch,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_clk,
  input  logic             cell_out
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = 8;

  state_t           state, nstate;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic [IW-1:0]    idx;
  logic             seen, glitch;
  logic             ld, done, adv, last, busy;
  logic [CW-1:0]    ldv;

  sfq_gap_counter #(.W(CW)) u_gap (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ld),
    .val   (ldv),
    .done  (done)
  );

  assign last = (idx == IW'(WIDTH - 1));
  assign busy = (state != S_IDLE)
    && (state != S_DONE);

  // next state, gap-counter loads and bit advance
  always_comb begin
    nstate = state;
    ld     = 1'b0;
    ldv    = '0;
    adv    = 1'b0;
    unique case (state)
      S_IDLE:
        if (req_valid) nstate = S_FCLK;
      S_FCLK: begin
        nstate = S_FWIN;
        ld     = 1'b1;
        ldv    = CW'(OUT_WIN);
      end
      S_FWIN:
        if (done) begin
          if (HOLD_CYC > 0) begin
            nstate = S_FHOLD;
            ld     = 1'b1;
            ldv    = CW'(HOLD_CYC);
          end else begin
            nstate = S_A;
          end
        end
      S_FHOLD:
        if (done) nstate = S_A;
      S_A: begin
        nstate = S_SEP;
        ld     = 1'b1;
        ldv    = CW'(SEP_CYC);
      end
      S_SEP:
        if (done) nstate = S_B;
      S_B: begin
        nstate = S_SETUP;
        ld     = 1'b1;
        ldv    = CW'(SETUP_CYC);
      end
      S_SETUP:
        if (done) nstate = S_CLK;
      S_CLK: begin
        nstate = S_WIN;
        ld     = 1'b1;
        ldv    = CW'(OUT_WIN);
      end
      S_WIN:
        if (done) begin
          if (HOLD_CYC > 0) begin
            nstate = S_HOLD;
            ld     = 1'b1;
            ldv    = CW'(HOLD_CYC);
          end else begin
            nstate = last ? S_RESP : S_A;
            adv    = !last;
          end
        end
      S_HOLD:
        if (done) begin
          nstate = last ? S_RESP : S_A;
          adv    = !last;
        end
      S_RESP:
        nstate = S_DONE;
      S_DONE:
        if (rsp_ready) nstate = S_IDLE;
      default:
        nstate = S_IDLE;
    endcase
  end

  // state, operands, per-bit capture and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op_a         <= '0;
      op_b         <= '0;
      res          <= '0;
      idx          <= '0;
      seen         <= 1'b0;
      glitch       <= 1'b0;
      rsp_data     <= '0;
      rsp_mismatch <= 1'b0;
      rsp_glitch   <= 1'b0;
    end else begin
      state <= nstate;
      if (state == S_IDLE && req_valid) begin
        op_a   <= req_a;
        op_b   <= req_b;
        res    <= '0;
        idx    <= '0;
        seen   <= 1'b0;
        glitch <= 1'b0;
      end
      if (state == S_WIN) begin
        if (cell_out && seen) glitch <= 1'b1;
        seen <= seen | cell_out;
        if (done) begin
          res[idx] <= seen | cell_out;
          seen     <= 1'b0;
        end
      end else if (cell_out && busy) begin
        glitch <= 1'b1;
      end
      if (adv) idx <= idx + IW'(1);
      if (state == S_RESP) begin
        rsp_data     <= res;
        rsp_mismatch <= (res != (op_a ^ op_b));
        rsp_glitch   <= glitch | cell_out;
      end
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign cell_a    = (state == S_A) && op_a[idx];
  assign cell_b    = (state == S_B) && op_b[idx];
  assign cell_clk  = (state == S_FCLK)
    || (state == S_CLK);

  a_onehot: assert property (@(posedge clk)
    $onehot0({cell_a, cell_b, cell_clk}));

  a_params: assert property (@(posedge clk)
    spacing_ok(WIDTH, SEP_CYC, SETUP_CYC,
               OUT_WIN, HOLD_CYC));

  a_stable: assert property (@(posedge clk)
    disable iff (!rst_n)
    rsp_valid && !rsp_ready |=>
      $stable({rsp_data, rsp_mismatch, rsp_glitch}));

endmodule

// File: tb/tb_sfq_xor_sequencer.sv
// Bench for sfq_xor_sequencer with a 3-state XOR cell model.
// Vector table plus reset, backpressure and pulse-injection sequences.
module tb_sfq_xor_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_mismatch;
  logic       rsp_glitch;
  logic       cell_a, cell_b, cell_clk;
  logic       cell_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sfq_xor_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_mismatch (rsp_mismatch),
    .rsp_glitch   (rsp_glitch),
    .cell_a       (cell_a),
    .cell_b       (cell_b),
    .cell_clk     (cell_clk),
    .cell_out     (cell_out)
  );

  // cell model: clk emits out iff exactly one input pulse seen
  logic sa = 1'b0, sb = 1'b0, mout = 1'b0;
  logic inj = 1'b0;
  int   pc = 0;
  int   drop_bit = 8;

  always @(posedge clk) begin
    if (!rst_n) begin
      sa   <= 1'b0;
      sb   <= 1'b0;
      mout <= 1'b0;
      pc   <= 0;
    end else begin
      mout <= 1'b0;
      if (req_valid && req_ready) pc <= 0;
      if (cell_a) sa <= 1'b1;
      if (cell_b) sb <= 1'b1;
      if (cell_clk) begin
        mout <= (sa ^ sb) && (pc != 0)
          && ((pc - 1) != drop_bit);
        sa <= 1'b0;
        sb <= 1'b0;
        pc <= pc + 1;
      end
    end
  end

  assign cell_out = mout | inj;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         drop;
    int         inj1;
    int         inj2;
    logic [7:0] d;
    logic       m;
    logic       g;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       m;
    logic       g;
  } exp_t;

  vec_t tbl [9];
  exp_t sbq [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a,
                          input logic [7:0] b,
                          input int drop,
                          input logic [7:0] d,
                          input logic m,
                          input logic g);
    exp_t e;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    drop_bit  = drop;
    for (int w = 0; w < 300 && !req_ready; w++) begin
      @(posedge clk); #1;
    end
    chk("req_ready_wait", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.d = d;
    e.m = m;
    e.g = g;
    sbq.push_back(e);
    chk("req_ready_drop", 32'(req_ready), 0);
  endtask

  task automatic wait_rsp(input int inj1,
                          input int inj2,
                          output int n);
    n = 0;
    while (!rsp_valid && n < 400) begin
      inj = (n == inj1) || (n == inj2);
      chk("pulse_onehot",
          32'($onehot0({cell_a, cell_b, cell_clk})), 1);
      @(posedge clk); #1;
      n++;
    end
    inj = 1'b0;
    chk("rsp_timeout", 32'(rsp_valid), 1);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_size"}, 32'(sbq.size()), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_data"}, 32'(rsp_data), 32'(e.d));
      chk({tag, "_mismatch"},
          32'(rsp_mismatch), 32'(e.m));
      chk({tag, "_glitch"}, 32'(rsp_glitch), 32'(e.g));
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{8'hA5, 8'h0F, 8, -1, -1, 8'hAA, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 8, -1, -1, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'h08, 8'h00, 3, -1, -1, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h3C, 8'hC3, 8,  2, 78, 8'hFF, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 8, -1, -1, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'h5A, 8'h33, 8, 78, -1, 8'h69, 1'b0, 1'b1};
    tbl[6] = '{8'h80, 8'h01, 0, -1, -1, 8'h80, 1'b1, 1'b0};
    tbl[7] = '{8'h12, 8'h34, 8,  2, -1, 8'h26, 1'b0, 1'b1};
    tbl[8] = '{8'hA5, 8'h0F, 8, 30, -1, 8'hAA, 1'b0, 1'b1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_pulses",
        32'({cell_a, cell_b, cell_clk}), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].drop,
               tbl[i].d, tbl[i].m, tbl[i].g);
      wait_rsp(tbl[i].inj1, tbl[i].inj2, n);
      chk("latency", 32'(n), 120);
      check_rsp("vec");
      @(posedge clk); #1;
      chk("rsp_xfer", 32'(rsp_valid), 0);
    end

    // backpressure with a queued request
    rsp_ready = 1'b0;
    start_op(8'h12, 8'h34, 8, 8'h26, 1'b0, 1'b0);
    wait_rsp(-1, -1, n);
    chk("bp_latency", 32'(n), 120);
    req_a     = 8'h80;
    req_b     = 8'h01;
    req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_data", 32'(rsp_data), 32'h26);
    end
    check_rsp("bp");
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_xfer", 32'(rsp_valid), 0);
    chk("bp_idle", 32'(req_ready), 1);
    start_op(8'h80, 8'h01, 8, 8'h81, 1'b0, 1'b0);
    wait_rsp(-1, -1, n);
    chk("b2b_latency", 32'(n), 120);
    check_rsp("b2b");
    @(posedge clk); #1;

    // reset during bit 4 out window
    start_op(8'h5A, 8'h33, 8, 8'h69, 1'b0, 1'b0);
    n = 0;
    while (n < 71) begin
      @(posedge clk); #1;
      n++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_pulses",
        32'({cell_a, cell_b, cell_clk}), 0);
    chk("abort_valid", 32'(rsp_valid), 0);
    chk("abort_ready", 32'(req_ready), 1);
    if (sbq.size() > 0) void'(sbq.pop_back());
    start_op(8'hA5, 8'h0F, 8, 8'hAA, 1'b0, 1'b0);
    wait_rsp(-1, -1, n);
    chk("post_rst_latency", 32'(n), 120);
    check_rsp("post_rst");
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
